// File: rtl/riscv_soft_load_scoreboard.sv
// riscv_soft_load_scoreboard: in-order load scoreboard tracking in-flight load destinations
// for RAW/WAW stalls, response bypass and register-file writeback steering.
module riscv_soft_load_scoreboard #(
  parameter int MAX_LOADS    = 4,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             issue_valid,
  input  logic                             issue_kill,
  input  logic                             issue_is_load,
  input  logic                             issue_is_store,
  input  logic                             issue_wr_reg,
  input  logic [REG_ADDR_LEN-1:0]          issue_rd,
  input  logic [REG_ADDR_LEN-1:0]          issue_rs1,
  input  logic [REG_ADDR_LEN-1:0]          issue_rs2,
  input  logic                             issue_uses_rs1,
  input  logic                             issue_uses_rs2,
  input  logic                             d_cache_req_ready,
  output logic                             d_cache_req_valid,
  input  logic                             d_cache_resp_valid,
  output logic [REG_ADDR_LEN-1:0]          resp_rd,
  output logic                             resp_wr_reg,
  output logic                             fwd_rs1_resp,
  output logic                             fwd_rs2_resp,
  output logic                             stall_EX,
  output logic [$clog2(MAX_LOADS+1)-1:0]   outstanding,
  output logic                             resp_err
);
  localparam int NUM_REGS = 2**REG_ADDR_LEN;
  localparam int PW = $clog2(MAX_LOADS);
  localparam int CW = $clog2(MAX_LOADS+1);
  logic [REG_ADDR_LEN-1:0] r_fifo_rd [MAX_LOADS];
  logic [MAX_LOADS-1:0]    r_fifo_wr;
  logic [PW-1:0]           r_rd_ptr;
  logic [PW-1:0]           r_wr_ptr;
  logic [CW-1:0]           r_count;
  logic [NUM_REGS-1:0]     r_pending;
  logic                    r_resp_err;
  logic                    w_active;
  logic                    w_any;
  logic                    w_pop;
  logic [REG_ADDR_LEN-1:0] w_head_rd;
  logic                    w_head_wr;
  logic [NUM_REGS-1:0]     w_clear;
  logic [NUM_REGS-1:0]     w_set;
  logic [NUM_REGS-1:0]     w_eff;
  logic                    w_raw;
  logic                    w_waw;
  logic                    w_full;
  logic                    w_fire;
  assign w_active  = issue_valid && !issue_kill;
  assign w_any     = r_count != '0;
  assign w_pop     = d_cache_resp_valid && w_any;
  assign w_head_rd = r_fifo_rd[r_rd_ptr];
  assign w_head_wr = r_fifo_wr[r_rd_ptr];
  // The retiring load's destination is released this cycle, so its consumers bypass instead of stalling.
  assign w_clear   = (w_pop && w_head_wr) ? NUM_REGS'(1) << w_head_rd : '0;
  assign w_eff     = r_pending & ~w_clear;
  assign w_raw     = w_active && ((issue_uses_rs1 && issue_rs1 != '0 && w_eff[issue_rs1]) ||
                                  (issue_uses_rs2 && issue_rs2 != '0 && w_eff[issue_rs2]));
  assign w_waw     = w_active && issue_wr_reg && issue_rd != '0 && w_eff[issue_rd];
  assign w_full    = (r_count == CW'(MAX_LOADS)) && !w_pop;
  assign d_cache_req_valid = w_active && (issue_is_load || issue_is_store) && !w_raw && !w_waw &&
                             !(issue_is_load && w_full);
  assign stall_EX  = w_raw || w_waw || (w_active && issue_is_load && w_full) ||
                     (d_cache_req_valid && !d_cache_req_ready);
  assign w_fire    = d_cache_req_valid && d_cache_req_ready && issue_is_load;
  assign w_set     = (w_fire && issue_wr_reg && issue_rd != '0) ? NUM_REGS'(1) << issue_rd : '0;
  assign resp_rd      = w_any ? w_head_rd : '0;
  assign resp_wr_reg  = w_any && w_head_wr;
  assign fwd_rs1_resp = w_pop && w_head_wr && issue_uses_rs1 && issue_rs1 == w_head_rd && issue_rs1 != '0;
  assign fwd_rs2_resp = w_pop && w_head_wr && issue_uses_rs2 && issue_rs2 == w_head_rd && issue_rs2 != '0;
  assign outstanding  = r_count;
  assign resp_err     = r_resp_err;
  // Pointers wrap naturally because MAX_LOADS is a power of two.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < MAX_LOADS; i++) r_fifo_rd[i] <= '0;
      r_fifo_wr  <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pending  <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_fire) begin
        r_fifo_rd[r_wr_ptr] <= issue_rd;
        r_fifo_wr[r_wr_ptr] <= issue_wr_reg && issue_rd != '0;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= r_count + CW'(w_fire) - CW'(w_pop);
      r_pending  <= w_eff | w_set;
      r_resp_err <= r_resp_err || (d_cache_resp_valid && !w_any);
    end
endmodule

// File: tb/tb_riscv_soft_load_scoreboard.sv
// tb_riscv_soft_load_scoreboard: directed scenarios checked every cycle against a queue-based
// scoreboard model, plus hand-computed expectations at key points.
module tb_riscv_soft_load_scoreboard;
  localparam int ML = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic issue_valid, issue_kill, issue_is_load, issue_is_store, issue_wr_reg;
  logic [4:0] issue_rd, issue_rs1, issue_rs2;
  logic issue_uses_rs1, issue_uses_rs2, d_cache_req_ready, d_cache_resp_valid;
  logic d_cache_req_valid, resp_wr_reg, fwd_rs1_resp, fwd_rs2_resp, stall_EX, resp_err;
  logic [4:0] resp_rd;
  logic [2:0] outstanding;
  int n_pass = 0;
  int n_tot = 0;
  riscv_soft_load_scoreboard #(.MAX_LOADS(ML), .REG_ADDR_LEN(5)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_kill(issue_kill),
    .issue_is_load(issue_is_load), .issue_is_store(issue_is_store),
    .issue_wr_reg(issue_wr_reg), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .d_cache_req_ready(d_cache_req_ready), .d_cache_req_valid(d_cache_req_valid),
    .d_cache_resp_valid(d_cache_resp_valid), .resp_rd(resp_rd), .resp_wr_reg(resp_wr_reg),
    .fwd_rs1_resp(fwd_rs1_resp), .fwd_rs2_resp(fwd_rs2_resp), .stall_EX(stall_EX),
    .outstanding(outstanding), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  typedef struct packed {logic [4:0] rd; logic wr;} ent_t;
  ent_t m_q[$];
  bit   m_pend[32];
  bit   m_eff[32];
  bit   m_err;
  ent_t m_h;
  bit   m_pop, m_raw, m_waw, m_full, m_req, m_stall, m_act;
  always @(negedge clk) begin
    if (reset) begin
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_err = 0;
    end
    m_act = issue_valid && !issue_kill;
    m_pop = d_cache_resp_valid && m_q.size() != 0;
    m_h = (m_q.size() != 0) ? m_q[0] : '0;
    m_eff = m_pend;
    if (m_pop && m_h.wr) m_eff[m_h.rd] = 0;
    m_raw = m_act && ((issue_uses_rs1 && issue_rs1 != 0 && m_eff[issue_rs1]) ||
                      (issue_uses_rs2 && issue_rs2 != 0 && m_eff[issue_rs2]));
    m_waw = m_act && issue_wr_reg && issue_rd != 0 && m_eff[issue_rd];
    m_full = m_q.size() == ML && !m_pop;
    m_req = m_act && (issue_is_load || issue_is_store) && !m_raw && !m_waw && !(issue_is_load && m_full);
    m_stall = m_raw || m_waw || (m_act && issue_is_load && m_full) || (m_req && !d_cache_req_ready);
    chk("m_req_valid", d_cache_req_valid, m_req);
    chk("m_stall", stall_EX, m_stall);
    chk("m_resp_rd", resp_rd, m_h.rd);
    chk("m_resp_wr", resp_wr_reg, m_h.wr);
    chk("m_fwd1", fwd_rs1_resp, m_pop && m_h.wr && issue_uses_rs1 && issue_rs1 == m_h.rd && issue_rs1 != 0);
    chk("m_fwd2", fwd_rs2_resp, m_pop && m_h.wr && issue_uses_rs2 && issue_rs2 == m_h.rd && issue_rs2 != 0);
    chk("m_outstanding", outstanding, m_q.size());
    chk("m_resp_err", resp_err, m_err);
    if (!reset) begin
      if (d_cache_resp_valid && m_q.size() == 0) m_err = 1;
      if (m_pop) begin
        m_h = m_q.pop_front();
        if (m_h.wr) m_pend[m_h.rd] = 0;
      end
      if (m_req && d_cache_req_ready && issue_is_load) begin
        m_q.push_back('{rd: issue_rd, wr: issue_wr_reg && issue_rd != 0});
        if (issue_wr_reg && issue_rd != 0) m_pend[issue_rd] = 1;
      end
    end
  end
  task automatic drv(input bit v, k, ld, st, wr, input int rd, rs1, rs2, input bit u1, u2, rdy, rsp);
    issue_valid = v; issue_kill = k; issue_is_load = ld; issue_is_store = st; issue_wr_reg = wr;
    issue_rd = 5'(rd); issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2);
    issue_uses_rs1 = u1; issue_uses_rs2 = u2; d_cache_req_ready = rdy; d_cache_resp_valid = rsp;
  endtask
  task automatic idle(input bit rsp); drv(0,0,0,0,0,0,0,0,0,0,1,rsp); endtask
  task automatic load(input int rd, input bit rsp); drv(1,0,1,0,1,rd,0,0,0,0,1,rsp); endtask
  task automatic alu(input int rs1, rs2, input bit rsp); drv(1,0,0,0,1,30,rs1,rs2,1,1,1,rsp); endtask
  task automatic go; @(posedge clk); #1; endtask
  int exp_rd[4] = '{2, 3, 4, 9};
  initial begin
    idle(0);
    repeat (2) go();
    @(negedge clk);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_wr", resp_wr_reg, 0);
    go(); reset = 1'b0;
    load(5, 0); @(negedge clk); chk("raw_load_req", d_cache_req_valid, 1); go();
    alu(5, 0, 0); @(negedge clk); chk("raw_stall", stall_EX, 1); go(); go();
    alu(5, 0, 1); @(negedge clk);
    chk("raw_fwd1", fwd_rs1_resp, 1); chk("raw_nostall", stall_EX, 0); chk("raw_resp_rd", resp_rd, 5); go();
    for (int i = 1; i <= 4; i++) begin load(i, 0); go(); end
    load(9, 0); @(negedge clk);
    chk("full_req", d_cache_req_valid, 0); chk("full_stall", stall_EX, 1); chk("full_cnt", outstanding, 4); go();
    load(9, 1); @(negedge clk);
    chk("full_pop_req", d_cache_req_valid, 1); chk("full_pop_stall", stall_EX, 0); chk("full_pop_rd", resp_rd, 1); go();
    idle(0); @(negedge clk); chk("full_cnt_after", outstanding, 4); go();
    for (int i = 0; i < 4; i++) begin idle(1); @(negedge clk); chk("drain_rd", resp_rd, exp_rd[i]); go(); end
    load(7, 0); go();
    load(7, 0); @(negedge clk); chk("waw_stall", stall_EX, 1); chk("waw_req", d_cache_req_valid, 0); go();
    load(7, 1); @(negedge clk); chk("waw_release_req", d_cache_req_valid, 1); chk("waw_resp_rd", resp_rd, 7); go();
    alu(7, 0, 0); @(negedge clk); chk("waw_pend7", stall_EX, 1); go();
    idle(1); go();
    drv(1,0,1,0,1,0,0,0,0,0,1,0); go();
    alu(0, 0, 0); @(negedge clk); chk("x0_nostall", stall_EX, 0); chk("x0_wr", resp_wr_reg, 0); chk("x0_cnt", outstanding, 1); go();
    idle(1); @(negedge clk); chk("x0_resp_rd", resp_rd, 0); chk("x0_resp_wr", resp_wr_reg, 0); go();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) load(10 + i, i > 0); else idle(1);
      @(negedge clk);
      if (i > 0) chk("wrap_rd", resp_rd, 10 + i - 1);
      go();
    end
    drv(1,0,0,1,0,0,3,4,1,1,1,0); @(negedge clk); chk("store_req", d_cache_req_valid, 1); go();
    drv(1,1,1,0,1,12,0,0,0,0,1,0); @(negedge clk); chk("kill_req", d_cache_req_valid, 0); chk("store_no_entry", outstanding, 0); go();
    drv(1,0,1,0,1,12,0,0,0,0,0,0); @(negedge clk); chk("notready_stall", stall_EX, 1); go();
    drv(1,0,1,0,0,8,0,0,0,0,1,0); @(negedge clk); chk("notready_no_entry", outstanding, 0); go();
    alu(8, 8, 0); @(negedge clk); chk("nowr_nostall", stall_EX, 0); chk("nowr_resp_wr", resp_wr_reg, 0); go();
    idle(1); go();
    idle(1); @(negedge clk); chk("spurious_cnt", outstanding, 0); go();
    idle(0); @(negedge clk); chk("spurious_err", resp_err, 1); go();
    load(3, 0); go(); load(4, 0); go();
    alu(3, 4, 0); reset = 1'b1; #1;
    chk("async_rst_cnt", outstanding, 0); chk("async_rst_stall", stall_EX, 0); chk("async_rst_err", resp_err, 0);
    go(); reset = 1'b0;
    idle(1); @(negedge clk); chk("post_rst_err0", resp_err, 0); go();
    idle(0); @(negedge clk); chk("post_rst_err1", resp_err, 1); go();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/riscv_soft_load_scoreboard.md
RISCV_SOFT_LOAD_SCOREBOARD -- requirements
Module: riscv_soft_load_scoreboard

Interface
REQ-001 Parameter MAX_LOADS, 4, max in-flight loads; power of two, 2..16.
REQ-002 Parameter REG_ADDR_LEN, 5, register index width; NUM_REGS = 2**REG_ADDR_LEN.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 issue_valid  input  1  EX-stage instruction present.
REQ-006 issue_kill  input  1  EX instruction killed; no side effects.
REQ-007 issue_is_load / issue_is_store  input  1 each  memory op class.
REQ-008 issue_wr_reg  input  1  instruction writes rd.
REQ-009 issue_rd, issue_rs1, issue_rs2  input  REG_ADDR_LEN each  register indices.
REQ-010 issue_uses_rs1 / issue_uses_rs2  input  1 each  source actually read.
REQ-011 d_cache_req_ready  input  1  d_cache accepts request.
REQ-012 d_cache_req_valid  output  1  memory request offered.
REQ-013 d_cache_resp_valid  input  1  one load response, in issue order.
REQ-014 resp_rd  output  REG_ADDR_LEN  destination of retiring load.
REQ-015 resp_wr_reg  output  1  retiring load writes register file.
REQ-016 fwd_rs1_resp / fwd_rs2_resp  output  1 each  bypass response data to ALU port.
REQ-017 stall_EX  output  1  hold EX this cycle.
REQ-018 outstanding  output  $clog2(MAX_LOADS+1)  in-flight load count.
REQ-019 resp_err  output  1  sticky: response with no load outstanding.

Function
REQ-020 State: circular FIFO of MAX_LOADS entries {rd, wr}, rd_ptr, wr_ptr, count, pending[NUM_REGS-1:0], resp_err.
REQ-021 active = issue_valid && !issue_kill; pop = d_cache_resp_valid && count!=0.
REQ-022 clear_mask = one-hot of head rd when pop && head.wr, else 0; eff_pending = pending & ~clear_mask.
REQ-023 raw = active && ((uses_rs1 && rs1!=0 && eff_pending[rs1]) || (uses_rs2 && rs2!=0 && eff_pending[rs2])).
REQ-024 waw = active && issue_wr_reg && issue_rd!=0 && eff_pending[issue_rd].
REQ-025 full = (count==MAX_LOADS) && !pop; applies to loads only.
REQ-026 d_cache_req_valid = active && (is_load||is_store) && !raw && !waw && !(is_load && full); independent of req_ready.
REQ-027 stall_EX = raw || waw || (active && is_load && full) || (d_cache_req_valid && !d_cache_req_ready).
REQ-028 Load fire = d_cache_req_valid && d_cache_req_ready && is_load: write {rd, wr_reg && rd!=0} at wr_ptr, wr_ptr wraps MAX_LOADS-1 -> 0.
REQ-029 On fire with wr set, pending[rd] set next cycle; set wins over same-cycle clear of same index.
REQ-030 Pop: resp_rd/resp_wr_reg driven combinationally from head same cycle; rd_ptr advances with wrap; pending cleared per clear_mask.
REQ-031 When count==0: resp_rd=0, resp_wr_reg=0, fwd_*=0.
REQ-032 fwd_rs1_resp = pop && head.wr && uses_rs1 && rs1==head.rd && rs1!=0; rs2 likewise; such sources do not raise raw.
REQ-033 count: +1 on fire only, -1 on pop only, unchanged on both; never exceeds MAX_LOADS or underflows.
REQ-034 d_cache_resp_valid with count==0: ignored, resp_err set, held until reset.
REQ-035 Stores create no FIFO entry and expect no response.
REQ-036 Killed or non-memory instructions change no state; register 0 never marked pending.

Reset
REQ-037 reset asserted: immediately count=0, pointers=0, pending=0, resp_err=0; outstanding=0, resp_wr_reg=0.
REQ-038 reset mid-operation discards in-flight loads; responses arriving after reset release set resp_err.

Verification
REQ-039 Load x5 fires, next cycle ADD rs1=x5 -> stall_EX=1 until response; response cycle fwd_rs1_resp=1, stall_EX=0, resp_rd=5.
REQ-040 MAX_LOADS=4: four loads x1..x4 fire, fifth load stalls with d_cache_req_valid=0; same cycle as a response it fires, outstanding stays 4.
REQ-041 Load x7 pending, second load rd=x7 -> waw stall; on x7 response, second load fires, pending[7]=1 afterwards.
REQ-042 Load rd=x0 with wr_reg=1 -> entry wr=0, no pending, response gives resp_wr_reg=0; dependent on x0 never stalls.
REQ-043 Pointer wrap: 10 back-to-back load/response pairs, MAX_LOADS=4 -> resp_rd sequence matches issue order.
REQ-044 resp with outstanding=0 -> resp_err=1, count stays 0; reset mid-flight with 2 loads -> outstanding=0, pending all 0.
